// File: rtl/permutation_iterative_if.sv
// Start/done handshake and state bus of the iterative ASCON permutation.
// The master is the mode FSM; the slave is permutation_iterative.
interface permutation_iterative_if #(
    parameter int ROUND_W = 4
);
    logic               start_i;
    logic               mode_i;
    logic [319:0]       state_i;
    logic [319:0]       state_o;
    logic               busy_o;
    logic               done_o;
    logic [ROUND_W-1:0] round_o;

    modport master (
        output start_i, mode_i, state_i,
        input  state_o, busy_o, done_o, round_o
    );

    modport slave (
        input  start_i, mode_i, state_i,
        output state_o, busy_o, done_o, round_o
    );
endinterface

// File: rtl/permutation_iterative.sv
// Iterative ASCON p^a: one p_C/p_S/p_L round per clock, p12 or p6.
// State packs S_0 in bits [319:256] down to S_4 in bits [63:0].
module permutation_iterative #(
    parameter int ROUND_W = 4
) (
    input logic                    clock_i,
    input logic                    resetb_i,
    permutation_iterative_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    localparam logic [ROUND_W-1:0] LAST = ROUND_W'(11);
    localparam logic [ROUND_W-1:0] P6_R0 = ROUND_W'(6);

    fsm_t               fsm_q;
    fsm_t               fsm_d;
    logic [ROUND_W-1:0] cnt_q;
    logic [ROUND_W-1:0] cnt_d;
    logic [319:0]       reg_q;
    logic [319:0]       reg_d;

    logic [ROUND_W-1:0] r0;
    logic [ROUND_W-1:0] rnd;
    logic [319:0]       s_in;
    logic [319:0]       s_add;
    logic [319:0]       s_sub;
    logic [319:0]       s_lin;
    logic [7:0]         rc;

    function automatic logic [63:0] rotr(
        input logic [63:0] x,
        input int unsigned n
    );
        return (x >> n) | (x << (64 - n));
    endfunction

    assign r0 = bus.mode_i ? P6_R0 : '0;

    // Round input: fresh state_i on a start, the register while running.
    always_comb begin
        s_in = reg_q;
        rnd  = cnt_q;
        if (fsm_q != RUN) begin
            s_in = bus.state_i;
            rnd  = r0;
        end
    end

    // p_C: round constant into the low byte of S_2.
    always_comb begin
        rc    = 8'(((8'h0F - 8'(rnd)) << 4) | 8'(rnd));
        s_add = s_in;
        s_add[135:128] = s_in[135:128] ^ rc;
    end

    // p_S: 5-bit S-box applied bitsliced across all 64 columns.
    always_comb begin
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s_add[319:256] ^ s_add[63:0];
        x1 = s_add[255:192];
        x2 = s_add[191:128] ^ s_add[255:192];
        x3 = s_add[127:64];
        x4 = s_add[63:0] ^ s_add[127:64];
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        s_sub = {x0, x1, x2, x3, x4};
    end

    // p_L: per-word linear diffusion with fixed rotation pairs.
    always_comb begin
        logic [63:0] w0, w1, w2, w3, w4;
        w0 = s_sub[319:256];
        w1 = s_sub[255:192];
        w2 = s_sub[191:128];
        w3 = s_sub[127:64];
        w4 = s_sub[63:0];
        s_lin = {
            w0 ^ rotr(w0, 19) ^ rotr(w0, 28),
            w1 ^ rotr(w1, 61) ^ rotr(w1, 39),
            w2 ^ rotr(w2, 1) ^ rotr(w2, 6),
            w3 ^ rotr(w3, 10) ^ rotr(w3, 17),
            w4 ^ rotr(w4, 7) ^ rotr(w4, 41)
        };
    end

    // Sequencer: accept a start when not running, step rounds until 11.
    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        reg_d = reg_q;
        unique case (fsm_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    reg_d = s_lin;
                    cnt_d = r0 + ROUND_W'(1);
                    fsm_d = (r0 == LAST) ? DONE : RUN;
                    if (r0 == LAST) cnt_d = '0;
                end
            end
            RUN: begin
                reg_d = s_lin;
                if (cnt_q == LAST) begin
                    fsm_d = DONE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + ROUND_W'(1);
                end
            end
            default: begin
                fsm_d = IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // State, counter and FSM registers; reset aborts any run in flight.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            reg_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            reg_q <= reg_d;
        end
    end

    assign bus.state_o = reg_q;
    assign bus.busy_o  = (fsm_q == RUN);
    assign bus.done_o  = (fsm_q == DONE);
    assign bus.round_o = cnt_q;
endmodule

// File: tb/tb_permutation_iterative.sv
// Directed bench for permutation_iterative against a table-driven
// ASCON reference (S-box lookup per column, bitwise rotations).
module tb_permutation_iterative;
    localparam int RW = 4;

    localparam logic [4:0] SBOX [32] = '{
        5'd4,  5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9,  5'd2,
        5'd27, 5'd5,  5'd8,  5'd18, 5'd29, 5'd3,  5'd6,  5'd28,
        5'd30, 5'd19, 5'd7,  5'd14, 5'd0,  5'd13, 5'd17, 5'd24,
        5'd16, 5'd12, 5'd1,  5'd25, 5'd22, 5'd10, 5'd15, 5'd23
    };

    localparam logic [319:0] ST_A = {
        64'h80400c0600000000, 64'h0001020304050607,
        64'h08090a0b0c0d0e0f, 64'h0001020304050607,
        64'h08090a0b0c0d0e0f
    };
    localparam logic [319:0] ST_B = {
        64'hdeadbeefcafef00d, 64'h0123456789abcdef,
        64'hfedcba9876543210, 64'h5555aaaa5555aaaa,
        64'h0f0f0f0ff0f0f0f0
    };

    typedef struct {
        logic [319:0] st;
        logic         mode;
        logic [319:0] exp;
    } vec_t;

    logic clock_i;
    logic resetb_i;
    int   n_total;
    int   n_pass;
    int   n_fail;
    vec_t vecs [4];

    permutation_iterative_if #(.ROUND_W(RW)) bus ();

    permutation_iterative #(.ROUND_W(RW)) dut (
        .clock_i (clock_i),
        .resetb_i(resetb_i),
        .bus     (bus)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[(i + n) % 64];
        return y;
    endfunction

    function automatic logic [319:0] ref_ps(input logic [319:0] s, input int r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  c;
        logic [4:0]  o;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64 * i -: 64];
        x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
        for (int b = 0; b < 64; b++) begin
            c = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o = SBOX[c];
            for (int i = 0; i < 5; i++) y[i][b] = o[4 - i];
        end
        return {y[0], y[1], y[2], y[3], y[4]};
    endfunction

    function automatic logic [319:0] ref_round(input logic [319:0] s, input int r);
        logic [319:0] p;
        logic [63:0]  w [5];
        p = ref_ps(s, r);
        for (int i = 0; i < 5; i++) w[i] = p[319 - 64 * i -: 64];
        w[0] = w[0] ^ rr(w[0], 19) ^ rr(w[0], 28);
        w[1] = w[1] ^ rr(w[1], 61) ^ rr(w[1], 39);
        w[2] = w[2] ^ rr(w[2], 1) ^ rr(w[2], 6);
        w[3] = w[3] ^ rr(w[3], 10) ^ rr(w[3], 17);
        w[4] = w[4] ^ rr(w[4], 7) ^ rr(w[4], 41);
        return {w[0], w[1], w[2], w[3], w[4]};
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int r0);
        logic [319:0] t;
        t = s;
        for (int r = r0; r < 12; r++) t = ref_round(t, r);
        return t;
    endfunction

    task automatic chk(input string name, input logic [319:0] act,
                       input logic [319:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic busy,
                            input logic done, input logic [RW-1:0] rnd);
        chk({tag, " busy"}, 320'(bus.busy_o), 320'(busy));
        chk({tag, " done"}, 320'(bus.done_o), 320'(done));
        chk({tag, " round"}, 320'(bus.round_o), 320'(rnd));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int r0;
        n  = v.mode ? 6 : 12;
        r0 = v.mode ? 6 : 0;
        bus.state_i = v.st;
        bus.mode_i  = v.mode;
        bus.start_i = 1'b1;
        #1;
        chk({tag, " ps probe"}, dut.s_sub, ref_ps(v.st, r0));
        tick();
        bus.start_i = 1'b0;
        for (int k = 1; k <= n; k++) begin
            chk_outs(tag, k < n, k == n, (k < n) ? RW'(r0 + k) : '0);
            if (k < n) tick();
        end
        chk({tag, " result"}, bus.state_o, v.exp);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        vecs[0] = '{ST_A, 1'b0, ref_perm(ST_A, 0)};
        vecs[1] = '{ST_A, 1'b1, ref_perm(ST_A, 6)};
        vecs[2] = '{ST_B, 1'b0, ref_perm(ST_B, 0)};
        vecs[3] = '{'1, 1'b1, ref_perm('1, 6)};

        resetb_i    = 1'b0;
        bus.start_i = 1'b0;
        bus.mode_i  = 1'b0;
        bus.state_i = '0;
        tick();
        tick();
        chk("reset state", bus.state_o, '0);
        chk_outs("reset", 1'b0, 1'b0, '0);
        resetb_i = 1'b1;
        tick();
        chk_outs("idle", 1'b0, 1'b0, '0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Starts during a run must not disturb it.
        bus.state_i = ST_A;
        bus.mode_i  = 1'b0;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.state_i = ST_B;
        for (int e = 2; e <= 12; e++) begin
            bus.start_i = (e == 3 || e == 7);
            bus.mode_i  = (e == 7);
            tick();
            if (e == 11) chk_outs("ign e11", 1'b1, 1'b0, RW'(11));
        end
        bus.start_i = 1'b0;
        chk_outs("ign e12", 1'b0, 1'b1, '0);
        chk("ign result", bus.state_o, vecs[0].exp);

        // Start held high: one DONE cycle, then restart from state_i.
        bus.state_i = ST_A;
        bus.mode_i  = 1'b1;
        bus.start_i = 1'b1;
        for (int e = 1; e <= 6; e++) tick();
        chk_outs("b2b e6", 1'b0, 1'b1, '0);
        chk("b2b first", bus.state_o, vecs[1].exp);
        bus.state_i = ST_B;
        tick();
        chk_outs("b2b e7", 1'b1, 1'b0, RW'(7));
        bus.start_i = 1'b0;
        for (int e = 8; e <= 12; e++) tick();
        chk_outs("b2b e12", 1'b0, 1'b1, '0);
        chk("b2b second", bus.state_o, ref_perm(ST_B, 6));

        // Reset mid-run clears everything at once.
        bus.state_i = ST_A;
        bus.mode_i  = 1'b0;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int e = 2; e <= 5; e++) tick();
        chk_outs("pre rst", 1'b1, 1'b0, RW'(5));
        #2 resetb_i = 1'b0;
        #1;
        chk("rst async state", bus.state_o, '0);
        chk_outs("rst async", 1'b0, 1'b0, '0);
        tick();
        resetb_i = 1'b1;
        for (int e = 0; e < 3; e++) tick();
        chk("post rst state", bus.state_o, '0);
        chk_outs("post rst", 1'b0, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
